// File: rtl/mole_if.sv
// mole_if: signal bundle between the game controller / keypad (master) and
// the mole scheduler (slave).
//
// Signals
//   round_start  master->slave  1      one-cycle pulse; start a round (taken only when idle)
//   interval     master->slave  CNT_W  slot length in cycles, sampled with round_start
//   duration     master->slave  CNT_W  mole-visible cycles per slot, sampled with round_start
//   molenum      master->slave  3      moles in the round, sampled with round_start
//   hit          master->slave  1      one-cycle player strike strobe
//   hit_index    master->slave  4      hole struck, qualified by hit
//   mole_appear  slave->master  1      mole visible
//   mole_index   slave->master  4      hole of the current mole
//   hit_success  slave->master  1      one-cycle pulse: current mole was hit
//   round_over   slave->master  1      one-cycle pulse: round finished
//   mole_count   slave->master  3      moles issued so far this round
//
// Handshake: there is no backpressure. round_start and hit are
// single-cycle strobes, sampled on the rising clock edge they are high at.
// hit_success and round_over are single-cycle pulses; the other slave
// outputs are levels that hold their value until the scheduler changes them.
interface mole_if #(
  parameter int CNT_W = 27
);
  logic             round_start;
  logic [CNT_W-1:0] interval;
  logic [CNT_W-1:0] duration;
  logic [2:0]       molenum;
  logic             hit;
  logic [3:0]       hit_index;
  logic             mole_appear;
  logic [3:0]       mole_index;
  logic             hit_success;
  logic             round_over;
  logic [2:0]       mole_count;

  modport master (
    output round_start, interval, duration, molenum, hit, hit_index,
    input  mole_appear, mole_index, hit_success, round_over, mole_count
  );

  modport slave (
    input  round_start, interval, duration, molenum, hit, hit_index,
    output mole_appear, mole_index, hit_success, round_over, mole_count
  );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: per-round mole sequencer. On round_start (while idle) it
// latches interval/duration/molenum, then issues molenum moles one after
// another, each in a slot of interval cycles, visible for the first
// duration cycles of the slot at a pseudo-random hole. A matching hit
// while the mole is visible pulses hit_success and hides the mole for the
// rest of its slot. round_over pulses for one cycle after the last slot.
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   bus          slave    mole_if (config/hit in, mole status out)
//   dbg_state_o  out  2   current FSM state (IDLE=0, SHOW=1, HIDE=2, DONE=3)
module mole_scheduler #(
  parameter int          NUM_HOLES = 9,
  parameter int          CNT_W     = 27,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  mole_if.slave      bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_HIDE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Galois taps for x^16+x^14+x^13+x^11+1 in right-shift form.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [4:0]  NH        = 5'(NUM_HOLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] int_q, int_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [2:0]       molenum_q, molenum_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       mole_index_q, mole_index_d;
  logic [2:0]       mole_count_q, mole_count_d;
  logic             mole_appear_q;
  logic             hit_success_q;
  logic             round_over_q;

  logic [CNT_W-1:0] int_eff;
  logic [CNT_W-1:0] dur_eff;
  logic [CNT_W-1:0] slot_dur;
  logic [4:0]       hole_raw;
  logic [3:0]       hole;
  logic             valid_hit;
  logic             slot_last;
  logic             show_last;
  logic             start_slot;

  // Effective config: a zero interval still gives 1-cycle slots, and a
  // mole can never stay up longer than its slot.
  assign int_eff = (bus.interval == '0) ? CNT_W'(1) : bus.interval;
  assign dur_eff = (bus.duration < int_eff) ? bus.duration : int_eff;

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  // Fold the low nibble into 0..NUM_HOLES-1 with a single subtraction;
  // valid because NUM_HOLES >= 8 keeps the nibble below 2*NUM_HOLES.
  assign hole_raw = {1'b0, lfsr_q[3:0]};
  always_comb begin
    if (hole_raw >= NH) begin
      hole = 4'(hole_raw - NH);
    end else begin
      hole = hole_raw[3:0];
    end
  end

  assign valid_hit = (state_q == ST_SHOW) && bus.hit && (bus.hit_index == mole_index_q);
  assign slot_last = (cnt_q == int_q - CNT_W'(1));
  assign show_last = (cnt_q == dur_q - CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    int_d        = int_q;
    dur_d        = dur_q;
    molenum_d    = molenum_q;
    mole_index_d = mole_index_q;
    mole_count_d = mole_count_q;
    slot_dur     = dur_q;
    start_slot   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.round_start) begin
          int_d        = int_eff;
          dur_d        = dur_eff;
          molenum_d    = bus.molenum;
          mole_count_d = 3'd0;
          slot_dur     = dur_eff;
          if (bus.molenum == 3'd0) begin
            state_d = ST_DONE;
          end else begin
            start_slot = 1'b1;
          end
        end
      end
      ST_SHOW, ST_HIDE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Slot end outranks the hide transition so that a hit on the last
        // cycle of a slot still moves straight on to the next slot.
        if (slot_last) begin
          if (mole_count_q == molenum_q) begin
            state_d = ST_DONE;
          end else begin
            start_slot = 1'b1;
          end
        end else if ((state_q == ST_SHOW) && (show_last || valid_hit)) begin
          state_d = ST_HIDE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_slot) begin
      cnt_d        = '0;
      mole_index_d = hole;
      mole_count_d = mole_count_d + 3'd1;
      state_d      = (slot_dur == '0) ? ST_HIDE : ST_SHOW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      int_q         <= '0;
      dur_q         <= '0;
      molenum_q     <= 3'd0;
      lfsr_q        <= LFSR_SEED;
      mole_index_q  <= 4'd0;
      mole_count_q  <= 3'd0;
      mole_appear_q <= 1'b0;
      hit_success_q <= 1'b0;
      round_over_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      int_q         <= int_d;
      dur_q         <= dur_d;
      molenum_q     <= molenum_d;
      lfsr_q        <= lfsr_d;
      mole_index_q  <= mole_index_d;
      mole_count_q  <= mole_count_d;
      mole_appear_q <= (state_d == ST_SHOW);
      hit_success_q <= valid_hit;
      round_over_q  <= (state_d == ST_DONE);
    end
  end

  assign bus.mole_appear = mole_appear_q;
  assign bus.mole_index  = mole_index_q;
  assign bus.hit_success = hit_success_q;
  assign bus.round_over  = round_over_q;
  assign bus.mole_count  = mole_count_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_mole_scheduler.sv
module tb_mole_scheduler;
  localparam int          CNT_W     = 27;
  localparam int          NUM_HOLES = 9;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          MAXT      = 128;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mole_if #(.CNT_W(CNT_W)) bus ();

  mole_scheduler #(
    .NUM_HOLES(NUM_HOLES),
    .CNT_W    (CNT_W),
    .LFSR_SEED(SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- reference model helpers ----------------
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] n;
    n = v >> 1;
    if (v[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [3:0] hole_of(input logic [15:0] v);
    int r;
    r = int'(v[3:0]);
    if (r >= NUM_HOLES) r = r - NUM_HOLES;
    return 4'(r);
  endfunction

  // Free-running LFSR model: the generator advances once per clock.
  logic [15:0] lfsr_m;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else        lfsr_m <= lfsr_step(lfsr_m);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle plan: hit mode 0 none, 1 correct hole, 2 wrong hole, 3 random hole.
  int hmode[0:MAXT-1];
  bit rsmid[0:MAXT-1];
  logic [3:0] m_prev_idx = 4'd0;

  // Measurements of the last round.
  int m_over, m_app, m_run, m_suc, m_suc_cyc, m_cnt;

  task automatic clear_plan();
    for (int i = 0; i < MAXT; i++) begin
      hmode[i] = 0;
      rsmid[i] = 1'b0;
    end
  endtask

  // Start a round and check every cycle from start+1 to one idle cycle after
  // round_over. Expected values come from slot arithmetic: cycle t lies in
  // slot (t-1)/ie at offset (t-1)%ie; round_over at mn*ie+1.
  task automatic run_round(input int iv, input int du, input int mn);
    int ie, de, len, k, off, cur;
    bit hidden, vprev, valid;
    logic [15:0] lv;
    logic [3:0] hs[0:MAXT-1];
    int e_app[0:MAXT-1], e_idx[0:MAXT-1], e_cnt[0:MAXT-1];
    int e_suc[0:MAXT-1], e_ovr[0:MAXT-1];
    logic [3:0] didx[0:MAXT-1];
    bit dhit[0:MAXT-1];

    @(negedge clk);
    lv = lfsr_m;
    for (int j = 0; j < MAXT; j++) begin
      hs[j] = hole_of(lv);
      lv = lfsr_step(lv);
    end
    ie  = (iv == 0) ? 1 : iv;
    de  = (du < ie) ? du : ie;
    len = (mn == 0) ? 1 : mn * ie + 1;

    hidden = 1'b0;
    vprev  = 1'b0;
    for (int t = 1; t <= len + 1; t++) begin
      e_suc[t] = int'(vprev);
      if (t >= len) begin
        e_ovr[t] = (t == len) ? 1 : 0;
        e_app[t] = 0;
        e_cnt[t] = mn;
        e_idx[t] = (mn == 0) ? int'(m_prev_idx) : int'(hs[(mn - 1) * ie]);
      end else begin
        k   = (t - 1) / ie;
        off = (t - 1) % ie;
        if (off == 0) hidden = 1'b0;
        e_ovr[t] = 0;
        e_cnt[t] = k + 1;
        e_idx[t] = int'(hs[k * ie]);
        e_app[t] = ((off < de) && !hidden) ? 1 : 0;
      end
      cur = (t < len) ? hmode[t] : 0;
      dhit[t] = (cur != 0);
      case (cur)
        1:       didx[t] = 4'(e_idx[t]);
        2:       didx[t] = 4'(e_idx[t]) ^ 4'd1;
        3:       didx[t] = 4'($urandom_range(0, 15));
        default: didx[t] = 4'(t);
      endcase
      valid = dhit[t] && (e_app[t] == 1) && (int'(didx[t]) == e_idx[t]);
      if (valid) hidden = 1'b1;
      vprev = valid;
    end
    m_prev_idx = 4'(e_idx[len + 1]);

    bus.round_start = 1'b1;
    bus.interval    = CNT_W'(iv);
    bus.duration    = CNT_W'(du);
    bus.molenum     = 3'(mn);
    bus.hit         = 1'b0;
    m_over = 0; m_app = 0; m_run = 0; m_suc = 0; m_suc_cyc = 0; m_cnt = -1;
    cur = 0;
    for (int t = 1; t <= len + 1; t++) begin
      @(negedge clk);
      bus.round_start = rsmid[t] && (t < len);
      if (bus.round_start) begin
        bus.interval = CNT_W'(3);
        bus.duration = CNT_W'(1);
        bus.molenum  = 3'd7;
      end
      bus.hit       = dhit[t];
      bus.hit_index = didx[t];
      chk($sformatf("appear t=%0d", t),  int'(bus.mole_appear), e_app[t]);
      chk($sformatf("index t=%0d", t),   int'(bus.mole_index),  e_idx[t]);
      chk($sformatf("count t=%0d", t),   int'(bus.mole_count),  e_cnt[t]);
      chk($sformatf("success t=%0d", t), int'(bus.hit_success), e_suc[t]);
      chk($sformatf("over t=%0d", t),    int'(bus.round_over),  e_ovr[t]);
      if (bus.round_over && m_over == 0) m_over = t;
      if (bus.hit_success) begin
        m_suc++;
        if (m_suc_cyc == 0) m_suc_cyc = t;
      end
      if (bus.mole_appear) begin
        m_app++;
        cur++;
        if (cur > m_run) m_run = cur;
      end else begin
        cur = 0;
      end
      if (t == len + 1) m_cnt = int'(bus.mole_count);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    int iv;
    int du;
    int mn;
    int exp_over;  // cycle of round_over after start
    int exp_app;   // total mole-visible cycles
    int exp_run;   // longest continuous visible run
    int exp_cnt;   // mole_count after the round
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{10,  4, 2, 21,  8,  4, 2};  // two slots, no hits
    tbl[1] = '{ 7,  3, 0,  1,  0,  0, 0};  // empty round
    tbl[2] = '{ 8, 20, 3, 25, 24, 24, 3};  // duration clipped to interval
    tbl[3] = '{ 0,  5, 3,  4,  3,  3, 3};  // zero interval -> 1-cycle slots
    tbl[4] = '{ 5,  0, 2, 11,  0,  0, 2};  // zero duration -> never visible
    tbl[5] = '{ 3,  1, 7, 22,  7,  1, 7};  // full mole count

    bus.round_start = 1'b0;
    bus.interval    = '0;
    bus.duration    = '0;
    bus.molenum     = 3'd0;
    bus.hit         = 1'b0;
    bus.hit_index   = 4'd0;

    // reset state
    repeat (3) @(negedge clk);
    chk("reset appear",  int'(bus.mole_appear), 0);
    chk("reset index",   int'(bus.mole_index),  0);
    chk("reset count",   int'(bus.mole_count),  0);
    chk("reset success", int'(bus.hit_success), 0);
    chk("reset over",    int'(bus.round_over),  0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      clear_plan();
      run_round(tbl[i].iv, tbl[i].du, tbl[i].mn);
      chk($sformatf("tbl%0d over_cycle", i), m_over, tbl[i].exp_over);
      chk($sformatf("tbl%0d appear_total", i), m_app, tbl[i].exp_app);
      chk($sformatf("tbl%0d longest_run", i), m_run, tbl[i].exp_run);
      chk($sformatf("tbl%0d final_count", i), m_cnt, tbl[i].exp_cnt);
    end

    // correct hit at slot cycle 2
    clear_plan();
    hmode[3] = 1;
    run_round(10, 4, 1);
    chk("hit success_count", m_suc, 1);
    chk("hit success_cycle", m_suc_cyc, 4);
    chk("hit appear_total", m_app, 3);
    chk("hit over_cycle", m_over, 11);

    // wrong hole while visible, then correct hole while hidden
    clear_plan();
    hmode[2] = 2;
    hmode[6] = 1;
    run_round(10, 4, 1);
    chk("miss success_count", m_suc, 0);
    chk("miss appear_total", m_app, 4);

    // hit on the last cycle of a slot
    clear_plan();
    hmode[4] = 1;
    run_round(4, 4, 2);
    chk("lastcyc success_cycle", m_suc_cyc, 5);
    chk("lastcyc appear_total", m_app, 8);
    chk("lastcyc over_cycle", m_over, 9);

    // round_start mid-round is ignored
    clear_plan();
    rsmid[5] = 1'b1;
    run_round(10, 4, 2);
    chk("midstart over_cycle", m_over, 21);
    chk("midstart final_count", m_cnt, 2);
    chk("midstart appear_total", m_app, 8);

    // asynchronous reset while a mole is visible
    clear_plan();
    @(negedge clk);
    bus.round_start = 1'b1;
    bus.interval    = CNT_W'(10);
    bus.duration    = CNT_W'(4);
    bus.molenum     = 3'd2;
    @(negedge clk);
    bus.round_start = 1'b0;
    @(negedge clk);
    chk("prereset appear", int'(bus.mole_appear), 1);
    chk("prereset count", int'(bus.mole_count), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset appear",  int'(bus.mole_appear), 0);
    chk("midreset index",   int'(bus.mole_index),  0);
    chk("midreset count",   int'(bus.mole_count),  0);
    chk("midreset success", int'(bus.hit_success), 0);
    chk("midreset over",    int'(bus.round_over),  0);
    m_prev_idx = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("postreset over", int'(bus.round_over), 0);
    chk("postreset appear", int'(bus.mole_appear), 0);
    run_round(4, 2, 2);
    chk("postreset over_cycle", m_over, 9);

    // randomized rounds against the model
    for (int r = 0; r < 30; r++) begin
      int iv, du, mn;
      clear_plan();
      iv = $urandom_range(0, 12);
      du = $urandom_range(0, 14);
      mn = $urandom_range(0, 7);
      for (int t = 1; t < MAXT; t++) begin
        if ($urandom_range(0, 9) < 3) hmode[t] = $urandom_range(1, 3);
        if ($urandom_range(0, 19) == 0) rsmid[t] = 1'b1;
      end
      run_round(iv, du, mn);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    n_errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
